// File: rtl/rf_access_ctrl.sv
// Initiator-side sequencer for REGISTER_FILE_32x32: decodes an R-type word, reads rs/rt,
// hands the operands to the ALU and writes the returned result back to rd.
module rf_access_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int RD_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  INSTR_VALID,
  output logic                  INSTR_READY,
  input  logic [31:0]           INSTR,
  output logic                  OPND_VALID,
  input  logic                  OPND_READY,
  output logic [DATA_WIDTH-1:0] OPND_A,
  output logic [DATA_WIDTH-1:0] OPND_B,
  input  logic                  RES_VALID,
  output logic                  RES_READY,
  input  logic [DATA_WIDTH-1:0] RES_DATA,
  input  logic                  RES_WE,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R2,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
  output logic [DATA_WIDTH-1:0] RF_DATA_W,
  output logic                  RF_READ,
  output logic                  RF_WRITE,
  output logic                  BUSY
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    OPND,
    WB,
    WRITE
  } state_t;

  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

  state_t                state;
  state_t                state_nxt;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_nxt;
  logic [ADDR_WIDTH-1:0] rd_q;
  logic [ADDR_WIDTH-1:0] rd_nxt;
  logic [ADDR_WIDTH-1:0] addr_r1_nxt;
  logic [ADDR_WIDTH-1:0] addr_r2_nxt;
  logic [ADDR_WIDTH-1:0] addr_w_nxt;
  logic [DATA_WIDTH-1:0] opnd_a_nxt;
  logic [DATA_WIDTH-1:0] opnd_b_nxt;
  logic [DATA_WIDTH-1:0] data_w_nxt;

  // Opcode, shamt and funct fields are not this block's concern.
  logic unused_instr;
  assign unused_instr = ^{INSTR[31:26], INSTR[10:0]};

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt_q;
    rd_nxt      = rd_q;
    addr_r1_nxt = RF_ADDR_R1;
    addr_r2_nxt = RF_ADDR_R2;
    addr_w_nxt  = RF_ADDR_W;
    opnd_a_nxt  = OPND_A;
    opnd_b_nxt  = OPND_B;
    data_w_nxt  = RF_DATA_W;

    case (state)
      IDLE: begin
        if (INSTR_VALID) begin
          addr_r1_nxt = ADDR_WIDTH'(INSTR[25:21]);
          addr_r2_nxt = ADDR_WIDTH'(INSTR[20:16]);
          rd_nxt      = ADDR_WIDTH'(INSTR[15:11]);
          cnt_nxt     = CNT_LOAD;
          state_nxt   = READ;
        end
      end
      // The read address registers double as the latched rs/rt for the r0 check.
      READ: begin
        if (cnt_q == '0) begin
          opnd_a_nxt = (RF_ADDR_R1 == '0) ? '0 : RF_DATA_R1;
          opnd_b_nxt = (RF_ADDR_R2 == '0) ? '0 : RF_DATA_R2;
          state_nxt  = OPND;
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      OPND: begin
        if (OPND_READY) state_nxt = WB;
      end
      WB: begin
        if (RES_VALID) begin
          if (RES_WE && (rd_q != '0)) begin
            addr_w_nxt = rd_q;
            data_w_nxt = RES_DATA;
            state_nxt  = WRITE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so every output comes straight from a flop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      cnt_q       <= '0;
      rd_q        <= '0;
      INSTR_READY <= 1'b1;
      OPND_VALID  <= 1'b0;
      RES_READY   <= 1'b0;
      RF_READ     <= 1'b0;
      RF_WRITE    <= 1'b0;
      BUSY        <= 1'b0;
      OPND_A      <= '0;
      OPND_B      <= '0;
      RF_ADDR_R1  <= '0;
      RF_ADDR_R2  <= '0;
      RF_ADDR_W   <= '0;
      RF_DATA_W   <= '0;
    end else begin
      state       <= state_nxt;
      cnt_q       <= cnt_nxt;
      rd_q        <= rd_nxt;
      INSTR_READY <= (state_nxt == IDLE);
      OPND_VALID  <= (state_nxt == OPND);
      RES_READY   <= (state_nxt == WB);
      RF_READ     <= (state_nxt == READ);
      RF_WRITE    <= (state_nxt == WRITE);
      BUSY        <= (state_nxt != IDLE);
      OPND_A      <= opnd_a_nxt;
      OPND_B      <= opnd_b_nxt;
      RF_ADDR_R1  <= addr_r1_nxt;
      RF_ADDR_R2  <= addr_r2_nxt;
      RF_ADDR_W   <= addr_w_nxt;
      RF_DATA_W   <= data_w_nxt;
    end
  end

endmodule
